// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
    localparam int unsigned REG_ZERO  = 0;

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: flush > issue > writeback clear > hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NUM_RD = 2,
    parameter  int unsigned NUM_WR = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR-1:0]    wr_clr_busy,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic [NREGS-1:0]     busy_vec
);

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             clr_hit;

    always_comb begin
        busy_nxt = busy;
        clr_hit  = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int unsigned r = 1; r < NREGS; r++) begin
                clr_hit = 1'b0;
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_clr_busy[j] && wr_addr[j*AW +: AW] == AW'(r))
                        clr_hit = 1'b1;
                end
                // A newer producer issued this cycle outranks the retiring one.
                if (iss_en && iss_addr == AW'(r))
                    busy_nxt[r] = 1'b1;
                else if (clr_hit)
                    busy_nxt[r] = 1'b0;
            end
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_comb begin
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++)
            rd_busy[k] = busy[rd_addr[k*AW +: AW]];
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned XLEN   = XLEN_DEF,
    parameter  int unsigned NREGS  = NREGS_DEF,
    parameter  int unsigned NUM_RD = 2,
    parameter  int unsigned NUM_WR = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic [NUM_WR-1:0]      wr_en,
    input  logic [NUM_WR*AW-1:0]   wr_addr,
    input  logic [NUM_WR*XLEN-1:0] wr_data,
    input  logic [NUM_WR-1:0]      wr_clr_busy,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       busy_vec
);

    logic [XLEN-1:0]   regs [NREGS];
    logic [NUM_RD-1:0] sb_rd_busy;

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_clr_busy (wr_clr_busy),
        .rd_addr     (rd_addr),
        .rd_busy     (sb_rd_busy),
        .busy_vec    (busy_vec)
    );

    // Ascending port order: the last non-blocking write (highest index) wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != AW'(REG_ZERO))
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;
    logic fwd_clr;

    always_comb begin
        rd_data = '0;
        rd_busy = sb_rd_busy;
        fwd_hit = 1'b0;
        fwd_clr = 1'b0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
            fwd_hit = 1'b0;
            fwd_clr = 1'b0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW]
                    && rd_addr[k*AW +: AW] != AW'(REG_ZERO)) begin
                    fwd_hit                 = 1'b1;
                    fwd_clr                 = wr_clr_busy[j];
                    rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                end
            end
            if (fwd_hit && fwd_clr && !(iss_en && iss_addr == rd_addr[k*AW +: AW]))
                rd_busy[k] = 1'b0;
        end
    end
`else
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_RD; k++)
            rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
    end

    assign rd_busy = sb_rd_busy;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed table-driven bench for regfile_mp_sb (2 read, 2 write ports).
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_clr_busy;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [31:0] busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp_sb #(
        .XLEN   (32),
        .NREGS  (32),
        .NUM_RD (2),
        .NUM_WR (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_clr_busy (wr_clr_busy),
        .iss_en      (iss_en),
        .iss_addr    (iss_addr),
        .flush       (flush),
        .busy_vec    (busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        reg_addr_t   wa0;
        xdata_t      wd0;
        reg_addr_t   wa1;
        xdata_t      wd1;
        logic [1:0]  clr;
        logic        ie;
        reg_addr_t   ia;
        logic        fl;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        xdata_t      e0;
        xdata_t      e1;
        logic [1:0]  eb;
        logic [31:0] ev;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(
        input logic [1:0] we, input reg_addr_t wa0, input xdata_t wd0,
        input reg_addr_t wa1, input xdata_t wd1, input logic [1:0] clr,
        input logic ie, input reg_addr_t ia, input logic fl,
        input reg_addr_t ra0, input reg_addr_t ra1,
        input xdata_t e0, input xdata_t e1, input logic [1:0] eb, input logic [31:0] ev);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.clr = clr; v.ie = ie; v.ia = ia; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ev = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        wr_en       = v.we;
        wr_addr     = {v.wa1, v.wa0};
        wr_data     = {v.wd1, v.wd0};
        wr_clr_busy = v.clr;
        iss_en      = v.ie;
        iss_addr    = v.ia;
        flush       = v.fl;
        rd_addr     = {v.ra1, v.ra0};
    endtask

    function automatic vec_t idle(input reg_addr_t ra0, input reg_addr_t ra1);
        return mk(2'b00, 0, 0, 0, 0, 2'b00, 1'b0, 0, 1'b0, ra0, ra1, 0, 0, 2'b00, 0);
    endfunction

    localparam logic [31:0] A = 32'h1111_1111;
    localparam logic [31:0] B = 32'h2222_2222;

    initial begin
        logic [31:0] exp_same;
        logic [31:0] exp_sbusy;

        tbl[0]  = mk(2'b11, 1, A, 2, B, 2'b00, 0, 0, 0,  5, 6, 0, 0, 2'b00, 32'h0);
        tbl[1]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 9, 0,  1, 2, A, B, 2'b00, 32'h0);
        tbl[2]  = mk(2'b01, 0, 32'hDEADBEEF, 0, 0, 2'b00, 1, 0, 0, 9, 0, 0, 0, 2'b01, 32'h200);
        tbl[3]  = mk(2'b10, 0, 0, 9, 32'h99, 2'b10, 0, 0, 0, 0, 1, 0, A, 2'b00, 32'h200);
        tbl[4]  = mk(2'b01, 9, 32'h98, 0, 0, 2'b01, 1, 9, 0, 1, 2, A, B, 2'b00, 32'h0);
        tbl[5]  = mk(2'b11, 3, 32'h1, 3, 32'h2, 2'b00, 0, 0, 0, 9, 1, 32'h98, A, 2'b01, 32'h200);
        tbl[6]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 1, 0,  3, 9, 32'h2, 32'h98, 2'b10, 32'h200);
        tbl[7]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 2, 0,  1, 2, A, B, 2'b01, 32'h202);
        tbl[8]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 31, 0, 31, 2, 0, B, 2'b10, 32'h206);
        tbl[9]  = mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 4, 1,  1, 2, A, B, 2'b11, 32'h8000_0206);
        tbl[10] = mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 5, 0,  4, 3, 0, 32'h2, 2'b00, 32'h0);
        tbl[11] = mk(2'b00, 5, 0, 5, 0, 2'b11, 0, 0, 0,  5, 9, 0, 32'h98, 2'b01, 32'h20);
        tbl[12] = mk(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0,  9, 1, 32'h98, A, 2'b00, 32'h20);

        rst = 1'b1;
        drive(idle(1, 2));
        #1;
        check("reset_rd0", rd_data[31:0], 32'h0);
        check("reset_busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check($sformatf("row%0d_rd0", i), rd_data[31:0], tbl[i].e0);
            check($sformatf("row%0d_rd1", i), rd_data[63:32], tbl[i].e1);
            check($sformatf("row%0d_rd_busy", i), {30'b0, rd_busy}, {30'b0, tbl[i].eb});
            check($sformatf("row%0d_busy_vec", i), busy_vec, tbl[i].ev);
        end

        // Write/read timing: x7 issued, then written back while being read.
`ifdef REGFILE_BYPASS_EN
        exp_same  = 32'hA5A5_A5A5;
        exp_sbusy = 32'h0;
`else
        exp_same  = 32'h0;
        exp_sbusy = 32'h1;
`endif
        @(negedge clk);
        drive(mk(2'b00, 0, 0, 0, 0, 2'b00, 1, 7, 0, 7, 1, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(2'b01, 7, 32'hA5A5_A5A5, 0, 0, 2'b01, 0, 0, 0, 7, 1, 0, 0, 0, 0));
        #1;
        check("wr_same_cycle_data", rd_data[31:0], exp_same);
        check("wr_same_cycle_busy", {31'b0, rd_busy[0]}, exp_sbusy);
        check("wr_same_cycle_busyvec", busy_vec, 32'h0000_00A0);
        @(negedge clk);
        drive(idle(7, 1));
        #1;
        check("wr_next_cycle_data", rd_data[31:0], 32'hA5A5_A5A5);
        check("wr_next_cycle_busy", {31'b0, rd_busy[0]}, 32'h0);

        // Asynchronous reset mid-cycle, then a write/issue discarded under reset.
        @(negedge clk);
        drive(mk(2'b01, 5, 32'h1234, 0, 0, 2'b01, 1, 10, 0, 5, 7, 0, 0, 0, 0));
        @(negedge clk);
        drive(idle(5, 7));
        #1;
        check("pre_rst_x5", rd_data[31:0], 32'h1234);
        check("pre_rst_busy_vec", busy_vec, 32'h400);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_x5", rd_data[31:0], 32'h0);
        check("async_rst_x7", rd_data[63:32], 32'h0);
        check("async_rst_busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        drive(mk(2'b01, 8, 32'hCAFE, 0, 0, 2'b00, 1, 8, 0, 8, 5, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;
        drive(idle(8, 5));
        #1;
        check("post_rst_x8", rd_data[31:0], 32'h0);
        check("post_rst_x5", rd_data[63:32], 32'h0);
        check("post_rst_busy_vec", busy_vec, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
